// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with HALT/RUN/STEP control,
// supervisor-bit protection, edge-triggered interrupt request and a
// retired-instruction counter.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
  parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] id,
  input  logic [31:0] jt,
  input  logic [2:0]  pcsel,
  input  logic        run,
  input  logic        step,
  input  logic        irq,
  output logic [31:0] pc,
  output logic [31:0] pc_inc,
  output logic [31:0] pc_offset,
  output logic        advance,
  output logic        halted,
  output logic        irq_req,
  output logic [31:0] icount
);

  localparam int unsigned W     = 32;
  localparam int unsigned LOW_W = W - 1;

  localparam logic [2:0] SEL_INC   = 3'd0;
  localparam logic [2:0] SEL_BR    = 3'd1;
  localparam logic [2:0] SEL_JMP   = 3'd2;
  localparam logic [2:0] SEL_XADR  = 3'd4;

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_advance;
  logic             r_halted;
  logic [W-1:0]     r_pc;
  logic [W-1:0]     r_icount;
  logic             r_irq_q;
  logic             r_irq_hist;
  logic             r_pending;

  logic [W-1:0]     w_pc_inc;
  logic [LOW_W-1:0] w_br_disp;
  logic [W-1:0]     w_pc_offset;
  logic [W-1:0]     w_jump;
  logic [W-1:0]     w_pc_next;
  logic             w_irq_rise;
  logic             w_irq_clr;
  logic             w_unused_bits;

  // Increment and branch arithmetic stay in the low 31 bits; bit 31 is carried through
  assign w_pc_inc    = {r_pc[W-1], r_pc[LOW_W-1:0] + LOW_W'(4)};
  assign w_br_disp   = {{13{id[15]}}, id[15:0], 2'b00};
  assign w_pc_offset = {r_pc[W-1], w_pc_inc[LOW_W-1:0] + w_br_disp};
  // Jumps may drop supervisor mode but never enter it
  assign w_jump      = {r_pc[W-1] & jt[W-1], jt[W-2:2], 2'b00};

  // Upper instruction bits and jump-target low bits do not affect the PC
  assign w_unused_bits = ^{id[31:16], jt[1:0]};

  // Next-PC select
  always_comb begin
    w_pc_next = ILLOP_VEC;
    case (pcsel)
      SEL_INC:  w_pc_next = w_pc_inc;
      SEL_BR:   w_pc_next = w_pc_offset;
      SEL_JMP:  w_pc_next = w_jump;
      SEL_XADR: w_pc_next = XADR_VEC;
      default:  w_pc_next = ILLOP_VEC;
    endcase
  end

  // Run-control FSM with registered advance/halted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_HALT;
      r_advance <= 1'b0;
      r_halted  <= 1'b1;
    end else begin
      case (r_state)
        S_HALT: begin
          if (run) begin
            r_state   <= S_RUN;
            r_advance <= 1'b1;
            r_halted  <= 1'b0;
          end else if (step) begin
            r_state   <= S_STEP;
            r_advance <= 1'b1;
            r_halted  <= 1'b0;
          end
        end
        S_RUN: begin
          if (!run) begin
            r_state   <= S_HALT;
            r_advance <= 1'b0;
            r_halted  <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_HALT;
          r_advance <= 1'b0;
          r_halted  <= 1'b1;
        end
      endcase
    end
  end

  // PC and retired-instruction counter update only when advancing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= RESET_VEC;
      r_icount <= '0;
    end else if (r_advance) begin
      r_pc     <= w_pc_next;
      r_icount <= r_icount + W'(1);
    end
  end

  assign w_irq_rise = r_irq_q & ~r_irq_hist;
  assign w_irq_clr  = r_advance & (pcsel == SEL_XADR);

  // Interrupt sampling and pending flag; a new edge wins over the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_q    <= 1'b0;
      r_irq_hist <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      r_irq_q    <= irq;
      r_irq_hist <= r_irq_q;
      r_pending  <= w_irq_rise | (r_pending & ~w_irq_clr);
    end
  end

  assign pc        = r_pc;
  assign pc_inc    = w_pc_inc;
  assign pc_offset = w_pc_offset;
  assign advance   = r_advance;
  assign halted    = r_halted;
  assign irq_req   = r_pending & ~r_pc[W-1];
  assign icount    = r_icount;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random stimulus checked against a
// behavioural model of the sequencer rules.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] id, jt;
  logic [2:0]  pcsel;
  logic        run, step, irq;
  logic [31:0] pc, pc_inc, pc_offset, icount;
  logic        advance, halted, irq_req;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .id(id), .jt(jt), .pcsel(pcsel),
    .run(run), .step(step), .irq(irq),
    .pc(pc), .pc_inc(pc_inc), .pc_offset(pc_offset),
    .advance(advance), .halted(halted), .irq_req(irq_req), .icount(icount)
  );

  always #20 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_HALT = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;

  logic [31:0] m_pc, m_icount;
  int          m_state;
  bit          m_pend, m_s1, m_s2;
  bit          m_adv, m_rise;

  function automatic logic [31:0] f_inc(input logic [31:0] p);
    logic [31:0] s;
    s = (p & 32'h7FFF_FFFF) + 32'd4;
    return (p & 32'h8000_0000) | (s & 32'h7FFF_FFFF);
  endfunction

  function automatic logic [31:0] f_off(input logic [31:0] p, input logic [31:0] instr);
    logic [31:0] disp, s;
    disp = {{16{instr[15]}}, instr[15:0]};
    s = (f_inc(p) & 32'h7FFF_FFFF) + disp * 32'd4;
    return (p & 32'h8000_0000) | (s & 32'h7FFF_FFFF);
  endfunction

  function automatic logic [31:0] f_next(input logic [31:0] p, input logic [2:0] sel,
                                         input logic [31:0] instr, input logic [31:0] tgt);
    if (sel == 3'd0) return f_inc(p);
    if (sel == 3'd1) return f_off(p, instr);
    if (sel == 3'd2) return (p & tgt & 32'h8000_0000) | (tgt & 32'h7FFF_FFFC);
    if (sel == 3'd4) return 32'h8000_0008;
    return 32'h8000_0004;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 32'h8000_0000; m_icount = 0; m_state = M_HALT;
      m_pend = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      m_adv  = (m_state != M_HALT);
      m_rise = m_s1 && !m_s2;
      if (m_adv) begin
        m_pc     = f_next(m_pc, pcsel, id, jt);
        m_icount = m_icount + 1;
      end
      m_pend = m_rise || (m_pend && !(m_adv && pcsel == 3'd4));
      m_s2 = m_s1;
      m_s1 = irq;
      if (m_state == M_HALT) begin
        if (run) m_state = M_RUN;
        else if (step) m_state = M_STEP;
      end else if (m_state == M_RUN) begin
        if (!run) m_state = M_HALT;
      end else begin
        m_state = M_HALT;
      end
    end
  end

  // Compare every output against the model away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc",        pc,                 m_pc);
      chk("pc_inc",    pc_inc,             f_inc(m_pc));
      chk("pc_offset", pc_offset,          f_off(m_pc, id));
      chk("advance",   32'(advance),       32'(m_state != M_HALT));
      chk("halted",    32'(halted),        32'(m_state == M_HALT));
      chk("irq_req",   32'(irq_req),       32'(m_pend && !m_pc[31]));
      chk("icount",    icount,             m_icount);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_step(input logic [2:0] sel);
    pcsel = sel;
    step  = 1'b1;
    cyc(1);
    chk("step_advance", 32'(advance), 32'd1);
    step = 1'b0;
    cyc(1);
    chk("step_back_halt", 32'(halted), 32'd1);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; irq = 1'b0;
    pcsel = 3'd0; id = '0; jt = '0;
    cyc(2);
    chk_en = 1'b1;
    chk("rst_pc",      pc,            32'h8000_0000);
    chk("rst_pc_inc",  pc_inc,        32'h8000_0004);
    chk("rst_advance", 32'(advance),  32'd0);
    chk("rst_halted",  32'(halted),   32'd1);
    chk("rst_irq_req", 32'(irq_req),  32'd0);
    chk("rst_icount",  icount,        32'd0);
    reset = 1'b0;
    cyc(1);

    // Free run from reset vector
    run = 1'b1; pcsel = 3'd0;
    cyc(1);
    chk("run_enter_pc", pc, 32'h8000_0000);
    chk("run_enter_adv", 32'(advance), 32'd1);
    cyc(3);
    chk("run3_pc", pc, 32'h8000_000C);
    chk("run3_icount", icount, 32'd3);
    run = 1'b0;
    cyc(1);
    chk("run_stop_pc", pc, 32'h8000_0010);
    chk("run_stop_halted", 32'(halted), 32'd1);

    // Jump clears supervisor, branch back, wrap of low 31 bits
    jt = 32'h0000_0010; do_step(3'd2);
    chk("jmp_user_pc", pc, 32'h0000_0010);
    id = 32'h0000_FFFE; pcsel = 3'd1; #1;
    chk("br_offset", pc_offset, 32'h0000_000C);
    do_step(3'd1);
    chk("br_pc", pc, 32'h0000_000C);
    jt = 32'h7FFF_FFFC; do_step(3'd2);
    chk("jmp_top_pc", pc, 32'h7FFF_FFFC);
    do_step(3'd0);
    chk("wrap_pc", pc, 32'h0000_0000);
    chk("wrap_icount", icount, 32'd8);

    // Supervisor jumps: bit 31 only cleared, low bits forced to zero
    do_step(3'd3);
    chk("illop_pc", pc, 32'h8000_0004);
    id = 32'h0000_003E; do_step(3'd1);
    chk("br_super_pc", pc, 32'h8000_0100);
    jt = 32'h0000_0203; do_step(3'd2);
    chk("jmp_clr_pc", pc, 32'h0000_0200);
    jt = 32'h0000_0100; do_step(3'd2);
    jt = 32'h8000_0040; do_step(3'd2);
    chk("jmp_noset_pc", pc, 32'h0000_0040);
    chk("jmp_icount", icount, 32'd13);

    // Single step pulse, then held step
    pcsel = 3'd0; step = 1'b1;
    cyc(1);
    chk("step1_adv", 32'(advance), 32'd1);
    chk("step1_halted", 32'(halted), 32'd0);
    step = 1'b0;
    cyc(1);
    chk("step1_pc", pc, 32'h0000_0044);
    chk("step1_icount", icount, 32'd14);
    chk("step1_adv_off", 32'(advance), 32'd0);
    step = 1'b1; cyc(5); step = 1'b0; cyc(3);
    chk("stephold_pc", pc, 32'h0000_0050);
    chk("stephold_icount", icount, 32'd17);

    // Interrupt request timing, clear on XADR, masked in supervisor mode
    irq = 1'b1;
    cyc(1);
    chk("irq_edge1", 32'(irq_req), 32'd0);
    cyc(1);
    chk("irq_edge2", 32'(irq_req), 32'd1);
    do_step(3'd4);
    chk("xadr_pc", pc, 32'h8000_0008);
    chk("xadr_irq_req", 32'(irq_req), 32'd0);
    irq = 1'b0; cyc(2); irq = 1'b1; cyc(3);
    chk("irq_super_masked", 32'(irq_req), 32'd0);
    jt = 32'h0000_0080; do_step(3'd2);
    chk("irq_user_again", 32'(irq_req), 32'd1);
    do_step(3'd4);
    do_step(3'd2);
    chk("irq_cleared", 32'(irq_req), 32'd0);
    irq = 1'b0; cyc(2); irq = 1'b1; cyc(2);
    chk("irq_pend_again", 32'(irq_req), 32'd1);
    irq = 1'b0; cyc(2);
    // New edge lands on the same edge as the clear
    pcsel = 3'd4; step = 1'b1; irq = 1'b1;
    cyc(1);
    step = 1'b0;
    cyc(1);
    chk("setwins_pc", pc, 32'h8000_0008);
    do_step(3'd2);
    chk("setwins_irq_req", 32'(irq_req), 32'd1);

    // Asynchronous reset in the middle of RUN
    run = 1'b1; pcsel = 3'd0;
    cyc(3);
    #5 reset = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h8000_0000);
    chk("arst_halted", 32'(halted), 32'd1);
    chk("arst_icount", icount, 32'd0);
    chk("arst_advance", 32'(advance), 32'd0);
    chk("arst_irq_req", 32'(irq_req), 32'd0);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    chk("arst_resume_pc", pc, 32'h8000_0000);
    cyc(1);
    chk("arst_run_pc", pc, 32'h8000_0004);
    chk("arst_run_icount", icount, 32'd1);

    // Random stimulus against the model
    run = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      pcsel = 3'($urandom_range(0, 7));
      id    = $urandom;
      jt    = $urandom;
      if ($urandom_range(0, 15) == 0) run = ~run;
      step = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) irq = ~irq;
      if ($urandom_range(0, 249) == 0) begin
        #5 reset = 1'b1;
        #3 reset = 1'b0;
      end
      cyc(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
